// File: rtl/uart_tx_serializer.sv
// Byte FIFO feeding an 8N1/8N2 asynchronous serial transmitter (LSB first, idle high).
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_reset_i,
    input  logic [7:0]                    uart_data,
    input  logic                          uart_valid,
    output logic                          tx_o,
    output logic                          busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(CLK_DIV);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic            full;
    logic            push;
    logic            pop;
    logic            bit_end;
    logic [7:0]      head;

    // Fullness comes from the registered level, so a push on a full FIFO is dropped
    // even when the transmitter pops in the same cycle.
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign push    = uart_valid && !full;
    assign bit_end = (timer_q == TW'(CLK_DIV - 1));
    assign head    = mem_q[rd_ptr_q];

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        timer_d   = bit_end ? '0 : timer_q + TW'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (level_q != '0) begin
                    pop      = 1'b1;
                    shift_d  = head;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                        bit_cnt_d = '0;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
`endif
            STOP: begin
                // bit_cnt doubles as the stop-bit index; the last stop cycle chains frames.
                if (bit_end) begin
                    if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                        if (level_q != '0) begin
                            pop      = 1'b1;
                            shift_d  = head;
`ifdef UART_TX_PARITY_EN
                            parity_d = ^head;
`endif
                            state_d  = START;
                        end else begin
                            state_d  = IDLE;
                        end
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The line is driven from a flop, so decode it from the next state.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase

        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        level_d    = level_q + LW'(push) - LW'(pop);
        overflow_d = uart_valid && full;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge wb_clk_i) begin
        if (wb_reset_i) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // NOTE: the storage array is not reset; the cleared level guarantees stale bytes are never read.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= uart_data;
        end
    end

    assign tx_o       = tx_q;
    assign busy       = (state_q != IDLE);
    assign fifo_full  = full;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: a line decoder checks frames against a scoreboard queue.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int DIV   = 4;
    localparam int FR    = (10 + PAR) * DIV;
    localparam int LASTK = 9 + PAR;
    localparam int LASTC = LASTK * DIV + DIV / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       tx, busy, full, ovf;
    logic [4:0] level;

    logic [7:0] data2 = 8'h00;
    logic       valid2 = 1'b0;
    logic       tx2, busy2, full2, ovf2;
    logic [4:0] level2;

    int tests_run = 0;
    int tests_failed = 0;
    int frames_rx = 0;
    int ovf_cnt = 0;
    int run_len = 0;
    int last_run = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLK_DIV(DIV), .FIFO_DEPTH(16), .STOP_BITS(1)) dut (
        .wb_clk_i(clk), .wb_reset_i(rst), .uart_data(data), .uart_valid(valid),
        .tx_o(tx), .busy(busy), .fifo_full(full), .fifo_level(level), .overflow(ovf)
    );

    uart_tx_serializer #(.CLK_DIV(DIV), .FIFO_DEPTH(16), .STOP_BITS(2)) dut2 (
        .wb_clk_i(clk), .wb_reset_i(rst), .uart_data(data2), .uart_valid(valid2),
        .tx_o(tx2), .busy(busy2), .fifo_full(full2), .fifo_level(level2), .overflow(ovf2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < bound) begin
            n++;
            @(negedge clk);
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Busy run-length and overflow pulse monitors.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            run_len++;
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (ovf === 1'b1) ovf_cnt++;
    end

    // Line decoder: sample each bit mid-period, compare against the scoreboard head.
    always begin : decoder
        logic [10:0] bits;
        logic        aborted;
        logic [7:0]  e;
        @(negedge clk iff (tx === 1'b0 && rst === 1'b0));
        aborted = 1'b0;
        bits    = '0;
        for (int c = 1; c <= LASTC; c++) begin
            @(negedge clk);
            if (rst === 1'b1) aborted = 1'b1;
            if (c % DIV == DIV / 2) bits[c / DIV] = tx;
        end
        if (!aborted) begin
            check("start_bit", {31'd0, bits[0]}, 32'd0);
            check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("data_byte", {24'd0, bits[8:1]}, {24'd0, e});
                if (PAR == 1) check("parity_bit", {31'd0, bits[9]}, {31'd0, ^e});
                check("stop_bit", {31'd0, bits[LASTK]}, 32'd1);
                frames_rx++;
            end
        end
    end

    initial begin
        int f0;
        int o0;
        int n;

        // Reset values
        repeat (3) tick();
        @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_level", {27'd0, level}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Single byte 0xA5: latency, level, busy length
        f0 = frames_rx;
        valid = 1'b1; data = 8'hA5; sb.push_back(8'hA5);
        tick();
        valid = 1'b0;
        @(negedge clk);
        check("a5_level_e0", {27'd0, level}, 32'd1);
        check("a5_tx_e0", {31'd0, tx}, 32'd1);
        check("a5_busy_e0", {31'd0, busy}, 32'd0);
        tick();
        @(negedge clk);
        check("a5_level_e1", {27'd0, level}, 32'd0);
        check("a5_tx_e1", {31'd0, tx}, 32'd0);
        check("a5_busy_e1", {31'd0, busy}, 32'd1);
        wait_idle(500);
        check("a5_busy_len", last_run, FR);
        check("a5_frames", frames_rx - f0, 1);

        // Three back-to-back bytes
        f0 = frames_rx;
        tick();
        for (int i = 1; i <= 3; i++) begin
            valid = 1'b1; data = 8'(i); sb.push_back(8'(i));
            tick();
        end
        valid = 1'b0;
        wait_idle(1000);
        check("b2b_busy_len", last_run, 3 * FR);
        check("b2b_frames", frames_rx - f0, 3);
        check("b2b_sb_empty", sb.size(), 0);

        // Overflow: 18 pushes, 17 accepted
        f0 = frames_rx;
        o0 = ovf_cnt;
        tick();
        for (int i = 0; i < 18; i++) begin
            valid = 1'b1; data = 8'h10 + 8'(i);
            if (i < 17) sb.push_back(8'h10 + 8'(i));
            @(negedge clk);
            if (i == 2) check("ovf_level_pushpop", {27'd0, level}, 32'd1);
            if (i == 17) begin
                check("ovf_full_e16", {31'd0, full}, 32'd1);
                check("ovf_level_e16", {27'd0, level}, 32'd16);
            end
            tick();
        end
        valid = 1'b0;
        @(negedge clk);
        check("ovf_pulse", {31'd0, ovf}, 32'd1);
        check("ovf_full_e17", {31'd0, full}, 32'd1);
        tick();
        @(negedge clk);
        check("ovf_pulse_end", {31'd0, ovf}, 32'd0);
        repeat (22) tick();
        @(negedge clk);
        check("ovf_full_e40", {31'd0, full}, 32'd1);
        tick();
        @(negedge clk);
        check("ovf_full_e41", {31'd0, full}, 32'd0);
        check("ovf_level_e41", {27'd0, level}, 32'd15);
        wait_idle(2000);
        check("ovf_frames", frames_rx - f0, 17);
        check("ovf_pulse_count", ovf_cnt - o0, 1);
        check("ovf_busy_len", last_run, 17 * FR);
        check("ovf_sb_empty", sb.size(), 0);

        // Reset during DATA bit 3 with 5 bytes queued
        f0 = frames_rx;
        tick();
        for (int i = 0; i < 6; i++) begin
            valid = 1'b1; data = 8'h60 + 8'(i); sb.push_back(8'h60 + 8'(i));
            tick();
        end
        valid = 1'b0;
        repeat (13) tick();
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_level", {27'd0, level}, 32'd0);
        repeat (200) @(negedge clk);
        check("mid_rst_frames", frames_rx - f0, 0);
        check("mid_rst_quiet_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_quiet_tx", {31'd0, tx}, 32'd1);

        // Two stop bits on the second instance: 0xFF then 0x00
        tick();
        valid2 = 1'b1; data2 = 8'hFF;
        tick();
        data2 = 8'h00;
        tick();
        valid2 = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("sb2_start", {31'd0, tx2}, 32'd0);
        tick();
        @(negedge clk);
        check("sb2_bit0", {31'd0, tx2}, 32'd1);
        repeat (32 + 4 * PAR) tick();
        @(negedge clk);
        n = 0;
        while (tx2 === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("sb2_stop_len", n, 8);
        check("sb2_next_start", {31'd0, tx2}, 32'd0);
        check("sb2_busy_chain", {31'd0, busy2}, 32'd1);
        repeat (60) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        // Parity bit value for 0x07 and 0x03
        tick();
        valid = 1'b1; data = 8'h07; sb.push_back(8'h07);
        tick();
        valid = 1'b0;
        repeat (38) tick();
        @(negedge clk);
        check("par_07", {31'd0, tx}, 32'd1);
        wait_idle(500);
        check("par_frame_len", last_run, 44);
        tick();
        valid = 1'b1; data = 8'h03; sb.push_back(8'h03);
        tick();
        valid = 1'b0;
        repeat (38) tick();
        @(negedge clk);
        check("par_03", {31'd0, tx}, 32'd0);
        wait_idle(500);
`endif

        check("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
